// File: rtl/p2s_arbiter.sv
// rtl/p2s_arbiter.sv - round-robin scheduler sharing one parallel-to-serial converter
// Optional urgent lane for requester 0 enabled by defining P2S_ARB_PRIORITY_EN.
module p2s_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       ack_o,
  input  logic                     ser_empty_i,
  output logic                     ser_load_o,
  output logic [WIDTH-1:0]         ser_data_o,
  output logic [ID_W-1:0]          cur_id_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               load_q, load_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ID_W:0]      pick;
  logic [ID_W-1:0]    win;

  // Returns {found, index}: first requester at or after ptr, wrapping.
  function automatic logic [ID_W:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
`ifdef P2S_ARB_PRIORITY_EN
    if (req[0]) res = {1'b1, {ID_W{1'b0}}};
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`ifdef P2S_ARB_PRIORITY_EN
      if (!res[ID_W] && idx != 0 && req[idx]) res = {1'b1, ID_W'(idx)};
`else
      if (!res[ID_W] && req[idx]) res = {1'b1, ID_W'(idx)};
`endif
    end
    return res;
  endfunction

  assign pick = pick_winner(req_i, rr_ptr_q);
  assign win  = pick[ID_W-1:0];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    load_d   = 1'b0;
    data_d   = data_q;
    id_d     = id_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ser_empty_i && pick[ID_W]) begin
          ack_d   = NUM_REQ'(1) << win;
          load_d  = 1'b1;
          data_d  = req_data_i[int'(win)*WIDTH +: WIDTH];
          id_d    = win;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
          if (win == ID_W'(NUM_REQ - 1)) rr_ptr_d = '0;
          else                           rr_ptr_d = win + 1'b1;
`ifdef P2S_ARB_PRIORITY_EN
          // Urgent-lane grants do not disturb the round-robin position.
          if (win == '0) rr_ptr_d = rr_ptr_q;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      ack_q    <= '0;
      load_q   <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      load_q   <= load_d;
      data_q   <= data_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ack_o      = ack_q;
  assign ser_load_o = load_q;
  assign ser_data_o = data_q;
  assign cur_id_o   = id_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: doc/p2s_arbiter.md
Name: p2s_arbiter

Overview:
- Round-robin scheduler that shares one Parallel_to_Serial converter between NUM_REQ requesters.
- Accepts a word from one requester at a time and loads it into the serializer.
- Holds the serializer for the WIDTH shift cycles, then moves to the next requester.
- Sits directly in front of the serializer: ser_load_o/ser_data_o drive its parallel input, and ser_empty_i is its empty_o.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, word width; must match the serializer word width.
- ID_W, 2, width of the requester index; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  NUM_REQ  per-requester request; hold high until the matching ack_o bit pulses.
- req_data_i  in  NUM_REQ*WIDTH  packed words; requester k uses bits [k*WIDTH +: WIDTH]; hold stable while req_i[k] is high.
- ack_o  out  NUM_REQ  one-hot, one-cycle pulse: the word from that requester was taken.
- ser_empty_i  in  1  serializer is idle and can accept a load.
- ser_load_o  out  1  one-cycle load strobe to the serializer.
- ser_data_o  out  WIDTH  word presented to the serializer; held until the next load.
- cur_id_o  out  ID_W  index of the requester being serialized.
- busy_o  out  1  high while a word is being shifted.
- done_o  out  1  one-cycle pulse when the last bit of a word has been shifted.

Behaviour:
- All outputs are registered.
- Reset values: ack_o=0, ser_load_o=0, ser_data_o=0, cur_id_o=0, busy_o=0, done_o=0; rr_ptr=0, cnt=0, state=IDLE.
- Reset has priority over every other event, including a word in flight. That word is abandoned, no done_o is issued, and no ack is repeated.
- States: IDLE and SHIFT.
- IDLE: a grant occurs when |req_i is high and ser_empty_i is high.
  - Winner = first requester with req_i set, searching from rr_ptr upward and wrapping at NUM_REQ-1 back to 0.
  - On that edge: ack_o <= onehot(winner); ser_load_o <= 1; ser_data_o <= the winner's word; cur_id_o <= winner; busy_o <= 1; cnt <= WIDTH-1; rr_ptr <= (winner+1) mod NUM_REQ; state <= SHIFT.
  - If ser_empty_i is low, or no request is present, stay in IDLE with all pulse outputs at 0.
- SHIFT: ack_o and ser_load_o return to 0.
  - If cnt==0: state <= IDLE, busy_o <= 0, done_o <= 1 for one cycle.
  - Otherwise cnt <= cnt-1.
  - SHIFT therefore lasts exactly WIDTH cycles.
  - req_i and ser_empty_i are ignored during SHIFT.
- Back-to-back grants are WIDTH+1 cycles apart: WIDTH shift cycles plus one IDLE cycle. The done_o pulse and the next ack_o pulse never occur in the same cycle.
- Requests are sampled only in IDLE. A request that drops before it is granted is lost with no ack. A new request raised during SHIFT waits for IDLE.
- rr_ptr advances only on a grant.
- A single persistent requester is granted every WIDTH+1 cycles.
- Invariants:
  - ack_o is one-hot or zero.
  - ack_o, ser_load_o and the busy_o rising edge occur in the same cycle.
  - busy_o and done_o are never high together.

Optional Feature:
- Macro: P2S_ARB_PRIORITY_EN.
- Defined:
  - Requester 0 is an urgent lane. If req_i[0] is high in a grant cycle, requester 0 wins regardless of rr_ptr, and rr_ptr is left unchanged.
  - Otherwise round-robin applies over requesters 1..NUM_REQ-1, starting from rr_ptr.
- Undefined: pure round-robin over all requesters; requester 0 has no special treatment.

Test Plan:
- Reset: hold reset 2 cycles with req_i=4'b1111. Every output stays 0 throughout; the first grant after release goes to requester 0.
- Single request: req_i=4'b0100, requester 2 word=4'b1010, ser_empty_i=1.
  - Next edge: ack_o=4'b0100, ser_load_o=1, ser_data_o=4'b1010, cur_id_o=2.
  - busy_o stays high 4 cycles, then done_o pulses once.
- Fairness: req_i=4'b1111 held, with words 1,2,3,4. Grants go to requesters 0,1,2,3,0 at 5-cycle spacing, and ser_data_o follows the sequence 1,2,3,4,1.
- Backpressure: req_i=4'b0010 with ser_empty_i=0 for 6 cycles. No ack and no load during that time; the grant occurs on the first edge after ser_empty_i rises.
- Reset mid-word: assert reset 2 cycles after a grant. Next edge: busy_o=0, no done_o, rr_ptr=0; after release, requester 0 is granted first if requesting.
- P2S_ARB_PRIORITY_EN defined: rr_ptr=2, req_i=4'b1101. Grant goes to requester 0 and rr_ptr stays 2; the next grant goes to requester 2. Undefined, the same stimulus grants requester 2 first.
